// File: rtl/hbus_wrreg_stm.sv
// rtl/hbus_wrreg_stm.sv - HyperBus register-write sequencer (WRREG leg of the top-level STM)
module hbus_wrreg_stm #(
   parameter int CSS_CYC = 1,
   parameter int CSH_CYC = 1,
   parameter int RWR_CYC = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stm_start,
   output logic        stm_end,
   input  logic [47:0] casig,
   input  logic [15:0] regdata,
   output logic        oe,
   output logic        oe_clk,
   output logic        csn,
   output logic [15:0] datain
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_CSS  = 4'd1;
   localparam logic [3:0] S_CA0  = 4'd2;
   localparam logic [3:0] S_CA1  = 4'd3;
   localparam logic [3:0] S_CA2  = 4'd4;
   localparam logic [3:0] S_DATA = 4'd5;
   localparam logic [3:0] S_CSH  = 4'd6;
   localparam logic [3:0] S_RWR  = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;

   localparam logic [3:0] CSS_LD = 4'(CSS_CYC);
   localparam logic [3:0] CSH_LD = 4'(CSH_CYC);
   localparam logic [3:0] RWR_LD = 4'(RWR_CYC);

   logic [3:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        start_prev_q;
   logic        abort_q, abort_d;
   logic [47:0] ca_q, ca_d;
   logic [15:0] wd_q, wd_d;
   logic        csn_q, csn_d;
   logic        oe_q, oe_d;
   logic        end_q, end_d;
   logic [15:0] din_q, din_d;
   logic        active;
   logic        abort_now;

   // Bus-owning states: a drop of stm_start here cuts the transfer short
   assign active = (state_q == S_CSS) || (state_q == S_CA0) || (state_q == S_CA1) ||
                   (state_q == S_CA2) || (state_q == S_DATA) || (state_q == S_CSH);
   assign abort_now = active && !stm_start;

   // Next-state, timer and latch logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      ca_d    = ca_q;
      wd_d    = wd_q;
      case (state_q)
         S_IDLE: begin
            // Only a genuine low-to-high transition starts a write
            if (stm_start && !start_prev_q) begin
               state_d = S_CSS;
               cnt_d   = CSS_LD;
               abort_d = 1'b0;
               ca_d    = {2'b01, casig[45:0]};
               wd_d    = regdata;
            end
         end
         S_CSS: begin
            if (cnt_q == 4'd1) state_d = S_CA0;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_CA0:  state_d = S_CA1;
         S_CA1:  state_d = S_CA2;
         S_CA2:  state_d = S_DATA;
         S_DATA: begin
            state_d = S_CSH;
            cnt_d   = CSH_LD;
         end
         S_CSH: begin
            if (cnt_q == 4'd1) begin
               state_d = S_RWR;
               cnt_d   = RWR_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RWR: begin
            // Recovery always runs to completion; a drop seen here skips DONE
            if (!stm_start) abort_d = 1'b1;
            if (cnt_q == 4'd1) state_d = (abort_q || !stm_start) ? S_IDLE : S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_DONE: begin
            if (!stm_start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_now) begin
         state_d = S_RWR;
         cnt_d   = RWR_LD;
         abort_d = 1'b1;
      end
   end

   // Output decode; outputs trail the state by one cycle, except an abort releases the bus at once
   always_comb begin
      csn_d = 1'b1;
      oe_d  = 1'b0;
      end_d = 1'b0;
      din_d = 16'h0000;
      if (!abort_now) begin
         case (state_q)
            S_CSS, S_CSH: csn_d = 1'b0;
            S_CA0: begin
               csn_d = 1'b0;
               oe_d  = 1'b1;
               din_d = ca_q[47:32];
            end
            S_CA1: begin
               csn_d = 1'b0;
               oe_d  = 1'b1;
               din_d = ca_q[31:16];
            end
            S_CA2: begin
               csn_d = 1'b0;
               oe_d  = 1'b1;
               din_d = ca_q[15:0];
            end
            S_DATA: begin
               csn_d = 1'b0;
               oe_d  = 1'b1;
               din_d = wd_q;
            end
            S_DONE:  end_d = 1'b1;
            default: ;
         endcase
      end
   end

   // State and output registers; start_prev resets high so a held request cannot fire after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         start_prev_q <= 1'b1;
         abort_q      <= 1'b0;
         ca_q         <= 48'h0;
         wd_q         <= 16'h0;
         csn_q        <= 1'b1;
         oe_q         <= 1'b0;
         end_q        <= 1'b0;
         din_q        <= 16'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         start_prev_q <= stm_start;
         abort_q      <= abort_d;
         ca_q         <= ca_d;
         wd_q         <= wd_d;
         csn_q        <= csn_d;
         oe_q         <= oe_d;
         end_q        <= end_d;
         din_q        <= din_d;
      end
   end

   assign csn     = csn_q;
   assign oe      = oe_q;
   assign oe_clk  = oe_q;
   assign stm_end = end_q;
   assign datain  = din_q;

endmodule

// File: tb/tb_hbus_wrreg_stm.sv
// tb/tb_hbus_wrreg_stm.sv - testbench for hbus_wrreg_stm
module tb_hbus_wrreg_stm;

   typedef logic [19:0] obs_t;   // {csn, oe, oe_clk, stm_end, datain}

   localparam obs_t IDLE_O = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
   localparam obs_t DONE_O = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
   localparam obs_t CSLO_O = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [47:0] casig;
   logic [15:0] regdata;
   logic        end_a, oe_a, oec_a, csn_a;
   logic [15:0] din_a;
   logic        end_b, oe_b, oec_b, csn_b;
   logic [15:0] din_b;
   logic        use_b;
   obs_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   hbus_wrreg_stm dut_a (
      .clk(clk), .rst(rst), .stm_start(start_a), .stm_end(end_a),
      .casig(casig), .regdata(regdata),
      .oe(oe_a), .oe_clk(oec_a), .csn(csn_a), .datain(din_a)
   );

   hbus_wrreg_stm #(.CSS_CYC(3), .CSH_CYC(2), .RWR_CYC(5)) dut_b (
      .clk(clk), .rst(rst), .stm_start(start_b), .stm_end(end_b),
      .casig(casig), .regdata(regdata),
      .oe(oe_b), .oe_clk(oec_b), .csn(csn_b), .datain(din_b)
   );

   function automatic obs_t observed();
      if (use_b) return {csn_b, oe_b, oec_b, end_b, din_b};
      return {csn_a, oe_a, oec_a, end_a, din_a};
   endfunction

   // Expected bus outputs k cycles after the start edge of an uninterrupted write
   function automatic obs_t model(int k, int css, int csh, int rwr,
                                  logic [47:0] ca, logic [15:0] d);
      int a;
      logic [15:0] w0;
      a  = 1 + css;
      w0 = {2'b01, ca[45:32]};
      if (k < 1)                  return IDLE_O;
      if (k < a)                  return CSLO_O;
      if (k == a)                 return {4'b0110, w0};
      if (k == a + 1)             return {4'b0110, ca[31:16]};
      if (k == a + 2)             return {4'b0110, ca[15:0]};
      if (k == a + 3)             return {4'b0110, d};
      if (k <= a + 3 + csh)       return CSLO_O;
      if (k <= a + 3 + csh + rwr) return IDLE_O;
      return DONE_O;
   endfunction

   task automatic set_start(input logic v);
      if (use_b) start_b = v;
      else       start_a = v;
   endtask

   task automatic step(input obs_t e, input string tag);
      obs_t o, x;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      o = observed();
      x = exp_q.pop_front();
      checks++;
      assert (o === x) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, x);
      end
   endtask

   // Full write: raise start, run to DONE, hold extra cycles, release and see stm_end fall
   task automatic run_seq(input string name, input int css, input int csh, input int rwr,
                          input logic [47:0] ca, input logic [15:0] d, input int hold);
      int done_k;
      done_k  = 1 + css + 4 + csh + rwr;
      casig   = ca;
      regdata = d;
      set_start(1'b1);
      for (int k = 0; k <= done_k + hold; k++) begin
         step(model(k, css, csh, rwr, ca, d), $sformatf("%s k=%0d", name, k));
         if (k == 0) begin
            casig   = ~ca;
            regdata = ~d;
         end
      end
      set_start(1'b0);
      step(DONE_O, $sformatf("%s release+1", name));
      step(IDLE_O, $sformatf("%s release+2", name));
   endtask

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      casig   = 48'h0;
      regdata = 16'h0;
      use_b   = 1'b0;
      @(negedge clk);
      step(IDLE_O, "reset_a");
      use_b = 1'b1;
      step(IDLE_O, "reset_b");
      rst   = 1'b0;
      use_b = 1'b0;
      step(IDLE_O, "post_reset");

      // Default timing
      run_seq("t1_default", 1, 1, 3, 48'h6000_0100_0000, 16'h8F1F, 0);

      // Forced R/W# and address-space bits
      run_seq("t2_forced", 1, 1, 3, 48'hC000_0100_0001, 16'h0000, 0);

      // Non-default timers
      use_b = 1'b1;
      run_seq("t3_params", 3, 2, 5, 48'h2A5A_1234_ABCD, 16'hBEEF, 0);
      use_b = 1'b0;

      // Abort during CA1, full RWR, then a fresh write
      casig   = 48'h6000_0100_0000;
      regdata = 16'h1234;
      set_start(1'b1);
      for (int k = 0; k <= 3; k++)
         step(model(k, 1, 1, 3, 48'h6000_0100_0000, 16'h1234), $sformatf("t4_pre k=%0d", k));
      set_start(1'b0);
      for (int k = 4; k <= 7; k++)
         step(IDLE_O, $sformatf("t4_abort k=%0d", k));
      run_seq("t4_restart", 1, 1, 3, 48'h0000_0000_0003, 16'h5A5A, 0);

      // Reset mid-transfer with start still high
      casig   = 48'h6000_0100_0000;
      regdata = 16'h8F1F;
      set_start(1'b1);
      for (int k = 0; k <= 3; k++)
         step(model(k, 1, 1, 3, 48'h6000_0100_0000, 16'h8F1F), $sformatf("t5_pre k=%0d", k));
      rst = 1'b1;
      step(IDLE_O, "t5_rst");
      rst = 1'b0;
      for (int k = 0; k < 4; k++)
         step(IDLE_O, $sformatf("t5_held k=%0d", k));
      set_start(1'b0);
      step(IDLE_O, "t5_low");
      run_seq("t5_restart", 1, 1, 3, 48'h6000_0100_0000, 16'h8F1F, 0);

      // Start held high past DONE for 20 cycles: no retrigger
      run_seq("t6_hold", 1, 1, 3, 48'h6000_0100_0000, 16'h00FF, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hbus_wrreg_stm.md
Name: hbus_wrreg_stm

Overview:
- HyperBus register-write sequencer. It is the WRREG leg of the controller top-level state machine.
- Driven by top-level stm_start[1]. Returns stm_end[1]. Its oe/oe_clk/csn/datain are muxed into the shared HyperBus output registers.
- Issues one configuration-register write: CS# setup, three 16-bit CA words, one 16-bit data word with zero latency, CS# hold, CS# high recovery.
- Never drives RWDS.

Parameters:
- CSS_CYC, 1: clk cycles CS# low before first CA word (tCSS); legal 1..15
- CSH_CYC, 1: clk cycles CS# low after data word with clock stopped (tCSH); legal 1..15
- RWR_CYC, 3: clk cycles CS# high before stm_end (tRWR); legal 1..15

Ports:
- clk  in  1  controller clock; one 16-bit bus word per cycle
- rst  in  1  synchronous, active-high reset
- stm_start  in  1  level request from top-level; held high until stm_end seen
- stm_end  out  1  level completion; high in DONE until stm_start low
- casig  in  48  command/address for the register (CA[47:0])
- regdata  in  16  value to write into the register
- oe  out  1  HyperBus DQ output enable
- oe_clk  out  1  HyperBus CK enable
- csn  out  1  HyperBus CS#, active low
- datain  out  16  word to DQ DDR output register; [15:8] on rising CK edge, [7:0] on falling

Behaviour:
- All outputs registered. Reset values: stm_end=0, oe=0, oe_clk=0, csn=1, datain=0, state=IDLE, counter=0.
- Start trigger:
  - Rising edge of stm_start, sampled in IDLE, defined as T0. Latches casig and regdata on that edge.
  - Inputs are ignored afterwards.
  - stm_start held high from a previous DONE never retriggers; a low cycle is required.
- CA forcing: latched CA[47] forced 0 (write) and CA[46] forced 1 (register space). CA[45:0] passed unchanged.
- States and outputs (values valid in the cycle after the entering edge):
  - IDLE: csn=1, oe=0, oe_clk=0, datain=0, stm_end=0.
  - CSS: csn=0, oe=0, oe_clk=0; lasts CSS_CYC cycles.
  - CA0: csn=0, oe=1, oe_clk=1, datain=CA[47:32].
  - CA1: same enables, datain=CA[31:16].
  - CA2: same enables, datain=CA[15:0].
  - DATA: same enables, datain=regdata. Zero latency, no RWDS sampling.
  - CSH: csn=0, oe=0, oe_clk=0, datain=0; lasts CSH_CYC cycles.
  - RWR: csn=1, oe=0, oe_clk=0; lasts RWR_CYC cycles.
  - DONE: stm_end=1, bus idle (csn=1). Stays until stm_start sampled low, then IDLE with stm_end=0 on the next cycle.
- Default timing:
  - csn low T1..T6.
  - CA words T2..T4, data T5.
  - csn high from T7.
  - stm_end first high at T10.
  - General formula: stm_end at T(1+CSS_CYC+4+CSH_CYC+RWR_CYC).
- Timers: one 4-bit down-counter, loaded on entry to CSS/CSH/RWR, exits at 1.
- Abort: stm_start sampled low in CSS, CA0..DATA or CSH.
  - Next cycle: csn=1, oe=0, oe_clk=0, datain=0; enter RWR for full RWR_CYC.
  - Then IDLE directly. stm_end is never asserted.
  - stm_start going low in RWR of a normal sequence has the same effect: skip DONE, go to IDLE.
- A stm_start rising edge arriving in RWR or DONE is ignored. A new sequence needs a rising edge seen in IDLE.
- rst at any cycle forces reset values on the next edge, including csn=1 mid-transfer.
- oe and oe_clk are always equal. oe_clk=1 only while csn=0.

Test Plan:
1. Defaults; casig=48'h6000_0100_0000, regdata=16'h8F1F, stm_start rises at T0 -> csn low T1..T6; datain 6000,0100,0000,8F1F at T2..T5 with oe=oe_clk=1; csn=1 T7..T9; stm_end=1 at T10; stm_start low at T11 -> stm_end=0 at T12.
2. casig=48'hC000_0100_0001, regdata=16'h0000 -> CA0 word 16'h4000, CA1 16'h0100, CA2 16'h0001 (forced bits verified).
3. CSS_CYC=3, CSH_CYC=2, RWR_CYC=5 -> first CA word at T4, data at T7, csn high from T10, stm_end at T15.
4. stm_start dropped at T3 (during CA1) -> T4: csn=1, oe=0, oe_clk=0; stm_end stays 0; IDLE after 3 RWR cycles; new rising edge then runs a full sequence.
5. rst pulsed at T4 -> next cycle csn=1, oe=0, oe_clk=0, datain=0, stm_end=0; stm_start still high afterwards does not start a sequence until it toggles low then high.
6. stm_start held high past DONE for 20 cycles -> stm_end remains 1 and no second bus transaction (csn stays 1).
